// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution datapath: pixel type, parameter legality and counter widths.
package cnn_pkg;

  localparam int PIXEL_W = 8;
  typedef logic [PIXEL_W-1:0] pixel_t;

  function automatic bit kernel_legal(input int k);
    return (k == 3) || (k == 5);
  endfunction

  function automatic bit dims_legal(input int k, input int w, input int h);
    return (w >= k) && (h >= k);
  endfunction

  function automatic int col_w(input int img_width);
    return $clog2(img_width);
  endfunction

  function automatic int row_w(input int img_height);
    return $clog2(img_height);
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Single-row delay line: dout is the value written DEPTH enables ago; state advances only on en.
// Circular register array, read-before-write at the same pointer; no backpressure of its own.
module line_buffer #(
  parameter int DEPTH      = 25,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    assign dout = din;
  end else begin : g_mem
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [PW-1:0]         ptr;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ptr <= '0;
      end else if (en) begin
        ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
      end
    end

    // Contents are deliberately left unreset; they are refilled before any window uses them.
    always_ff @(posedge clk) begin
      if (en) begin
        mem[ptr] <= din;
      end
    end

    assign dout = mem[ptr];
  end

endmodule

// File: rtl/sliding_window.sv
// Streams raster pixels into K-1 line buffers and a KxK shift window; one registered window per completing pixel.
// Window valid one cycle after the completing pixel; pixel_ready = !window_valid || window_ready.
module sliding_window
  import cnn_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pixel_valid,
  output logic                  pixel_ready,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  output logic                  window_valid,
  input  logic                  window_ready,
  output logic [DATA_WIDTH-1:0] window_out [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1],
  output logic                  frame_done
);

  localparam int K        = KERNEL_SIZE;
  localparam int COL_W    = col_w(IMG_WIDTH);
  localparam int ROW_W    = row_w(IMG_HEIGHT);
  localparam int LB_DEPTH = IMG_WIDTH - KERNEL_SIZE;

  if (!kernel_legal(K)) begin : g_bad_kernel
    $error("sliding_window: KERNEL_SIZE must be 3 or 5");
  end
  if (!dims_legal(K, IMG_WIDTH, IMG_HEIGHT)) begin : g_bad_dims
    $error("sliding_window: image dimensions must be >= KERNEL_SIZE");
  end

  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic                  accept;
  logic                  complete;
  logic                  last_px;
  logic [DATA_WIDTH-1:0] lb_out [0:K-2];

  assign pixel_ready = !window_valid || window_ready;
  assign accept      = pixel_valid && pixel_ready;
  assign complete    = accept && (row >= ROW_W'(K - 1)) && (col >= COL_W'(K - 1));
  assign last_px     = (row == ROW_W'(IMG_HEIGHT - 1)) && (col == COL_W'(IMG_WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_W'(IMG_WIDTH - 1)) begin
        col <= '0;
        row <= last_px ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Pixels leaving the left edge of window row r+1 re-enter at the right of row r one image row later.
  for (genvar i = 0; i < K - 1; i++) begin : g_lb
    line_buffer #(
      .DEPTH      (LB_DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_line_buffer (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (accept),
      .din   (window_out[i+1][0]),
      .dout  (lb_out[i])
    );
  end

  // The shift window doubles as the output register: it only moves on accept, and accept is
  // blocked while a presented window is stalled, so window_out stays stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          window_out[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          window_out[r][c] <= window_out[r][c+1];
        end
      end
      for (int r = 0; r < K - 1; r++) begin
        window_out[r][K-1] <= lb_out[r];
      end
      window_out[K-1][K-1] <= pixel_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= complete && last_px;
      if (complete) begin
        window_valid <= 1'b1;
      end else if (window_ready) begin
        window_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sliding_window.sv
// Scoreboard bench: expected windows are cut from a 2-D image model when a frame is issued;
// monitors pop and compare on every newly presented window of a K=3 5x5 and a K=5 6x6 instance.
module tb_sliding_window;
  import cnn_pkg::*;

  typedef struct {
    logic [199:0] win;
    bit           fd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       pv3, pr3, wv3, fd3;
  logic       wr3 = 1'b1;
  logic [7:0] pin3;
  logic [7:0] wo3 [0:2][0:2];
  logic       pv5, pr5, wv5, fd5, wr5;
  logic [7:0] pin5;
  logic [7:0] wo5 [0:4][0:4];

  sliding_window #(.KERNEL_SIZE(3), .DATA_WIDTH(8), .IMG_WIDTH(5), .IMG_HEIGHT(5)) dut3 (
    .clk(clk), .rst_n(rst_n), .pixel_valid(pv3), .pixel_ready(pr3), .pixel_in(pin3),
    .window_valid(wv3), .window_ready(wr3), .window_out(wo3), .frame_done(fd3));

  sliding_window #(.KERNEL_SIZE(5), .DATA_WIDTH(8), .IMG_WIDTH(6), .IMG_HEIGHT(6)) dut5 (
    .clk(clk), .rst_n(rst_n), .pixel_valid(pv5), .pixel_ready(pr5), .pixel_in(pin5),
    .window_valid(wv5), .window_ready(wr5), .window_out(wo5), .frame_done(fd5));

  logic [199:0] flat3, flat5;
  always_comb begin
    flat3 = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) flat3[(r*3+c)*8 +: 8] = wo3[r][c];
  end
  always_comb begin
    flat5 = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) flat5[(r*5+c)*8 +: 8] = wo5[r][c];
  end

  int     n_chk = 0;
  int     n_pass = 0;
  exp_t   q3[$];
  exp_t   q5[$];
  pixel_t img3 [0:24];
  pixel_t img5 [0:35];
  int     rmode = 0;
  int     acc12, acc28;
  int     win_cnt3 = 0;
  int     win_cnt5 = 0;
  int     wcyc3 [0:255];
  int     wcyc5 [0:15];

  task automatic check(input bit ok, input string name, input logic [207:0] act, input logic [207:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: every KxK sub-block of the image in raster order of its bottom-right pixel.
  task automatic push_frame3();
    exp_t e;
    for (int r0 = 0; r0 <= 2; r0++)
      for (int c0 = 0; c0 <= 2; c0++) begin
        e.win = '0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) e.win[(r*3+c)*8 +: 8] = img3[(r0+r)*5 + c0 + c];
        e.fd = (r0 == 2) && (c0 == 2);
        q3.push_back(e);
      end
  endtask

  task automatic push_frame5();
    exp_t e;
    for (int r0 = 0; r0 <= 1; r0++)
      for (int c0 = 0; c0 <= 1; c0++) begin
        e.win = '0;
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 5; c++) e.win[(r*5+c)*8 +: 8] = img5[(r0+r)*6 + c0 + c];
        e.fd = (r0 == 1) && (c0 == 1);
        q5.push_back(e);
      end
  endtask

  task automatic fill3(input bit rnd, input int base);
    for (int i = 0; i < 25; i++) img3[i] = rnd ? pixel_t'($urandom_range(0, 255)) : pixel_t'(base + i);
  endtask

  task automatic send_px3(input pixel_t v, input int idx, input bit tog);
    int w;
    pv3 = 1'b1;
    pin3 = v;
    w = 0;
    do begin @(negedge clk); w++; end while (!pr3 && w < 500);
    if (!pr3) check(pr3, "pixel_ready_timeout", pr3, 1);
    @(posedge clk); #1;
    if (idx == 12) acc12 = cyc;
    if (tog) begin pv3 = 1'b0; @(posedge clk); #1; end
  endtask

  task automatic send_frame3(input int npix, input bit tog);
    for (int i = 0; i < npix; i++) send_px3(img3[i], i, tog);
    pv3 = 1'b0;
  endtask

  task automatic send_frame5();
    for (int i = 0; i < 36; i++) begin
      pv5 = 1'b1;
      pin5 = img5[i];
      @(negedge clk);
      if (!pr5) check(pr5, "pixel_ready5", pr5, 1);
      @(posedge clk); #1;
      if (i == 28) acc28 = cyc;
    end
    pv5 = 1'b0;
  endtask

  task automatic drain3();
    int w;
    rmode = 0;
    w = 0;
    while ((q3.size() != 0 || wv3) && w < 100) begin @(negedge clk); w++; end
    check(q3.size() == 0, "drain3_queue_empty", q3.size(), 0);
    @(posedge clk); #1;
  endtask

  // window_ready driver: 0 = always ready, 1 = random, 2 = stall 4 cycles at the first window.
  int stall_cnt = 0;
  initial forever begin
    @(posedge clk); #1;
    case (rmode)
      0: wr3 = 1'b1;
      1: wr3 = 1'($urandom_range(0, 1));
      default: begin
        if (wv3 || stall_cnt > 0) stall_cnt++;
        wr3 = (stall_cnt >= 4);
      end
    endcase
    if (rmode != 2) stall_cnt = 0;
  end

  logic         p_v3 = 1'b0;
  logic         p_r3 = 1'b1;
  logic [199:0] p_w3;
  exp_t         e3, e5;
  always @(negedge clk) begin
    if (!rst_n) begin
      p_v3 = 1'b0;
      p_r3 = 1'b1;
    end else begin
      if (p_v3 && !p_r3) check(wv3 && flat3 == p_w3, "hold_window", {wv3, flat3}, {1'b1, p_w3});
      if (wv3 && !wr3) check(!pr3, "pixel_ready_backpressure", pr3, 0);
      if (wv3 && !(p_v3 && !p_r3)) begin
        wcyc3[win_cnt3 % 256] = cyc;
        win_cnt3++;
        check(q3.size() != 0, "unexpected_window3", flat3, 0);
        if (q3.size() != 0) begin
          e3 = q3.pop_front();
          check(flat3 == e3.win, "window3", flat3, e3.win);
          check(fd3 == e3.fd, "frame_done3", fd3, e3.fd);
        end
      end else begin
        check(!fd3, "frame_done3_stray", fd3, 0);
      end
      p_v3 = wv3;
      p_r3 = wr3;
      p_w3 = flat3;
    end
  end

  always @(negedge clk) begin
    if (rst_n && wv5) begin
      wcyc5[win_cnt5 % 16] = cyc;
      win_cnt5++;
      check(q5.size() != 0, "unexpected_window5", flat5, 0);
      if (q5.size() != 0) begin
        e5 = q5.pop_front();
        check(flat5 == e5.win, "window5", flat5, e5.win);
        check(fd5 == e5.fd, "frame_done5", fd5, e5.fd);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n = 1'b0;
    pv3 = 1'b0; pin3 = '0;
    pv5 = 1'b0; pin5 = '0; wr5 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check(wv3 == 1'b0, "reset_window_valid", wv3, 0);
    check(fd3 == 1'b0, "reset_frame_done", fd3, 0);
    check(flat3 == '0, "reset_window_out", flat3, 0);
    check(pr3 == 1'b1, "reset_pixel_ready", pr3, 1);
    check(wv5 == 1'b0 && flat5 == '0, "reset_dut5", {wv5, flat5}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Ramp frame, always ready: latency, 9 windows, frame_done on the last.
    base = win_cnt3;
    fill3(1'b0, 0); push_frame3();
    send_frame3(25, 1'b0);
    drain3();
    check(wcyc3[base % 256] == acc12, "first_window_latency", wcyc3[base % 256], acc12);
    check(win_cnt3 - base == 9, "window_count_s1", win_cnt3 - base, 9);

    // Consumer stalls at the first window.
    base = win_cnt3;
    fill3(1'b0, 0); push_frame3();
    rmode = 2;
    send_frame3(25, 1'b0);
    drain3();
    check(win_cnt3 - base == 9, "window_count_stall", win_cnt3 - base, 9);

    // Two back-to-back frames.
    base = win_cnt3;
    fill3(1'b0, 0); push_frame3();
    send_frame3(25, 1'b0);
    fill3(1'b0, 100); push_frame3();
    send_frame3(25, 1'b0);
    drain3();
    check(win_cnt3 - base == 18, "window_count_b2b", win_cnt3 - base, 18);

    // Reset after 7 pixels, then a clean frame must repeat the first scenario.
    fill3(1'b0, 0);
    send_frame3(7, 1'b0);
    rst_n = 1'b0;
    #2;
    check(wv3 == 1'b0 && fd3 == 1'b0, "midreset_flags", {wv3, fd3}, 0);
    check(flat3 == '0, "midreset_window_out", flat3, 0);
    check(pr3 == 1'b1, "midreset_pixel_ready", pr3, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    base = win_cnt3;
    push_frame3();
    send_frame3(25, 1'b0);
    drain3();
    check(wcyc3[base % 256] == acc12, "post_reset_latency", wcyc3[base % 256], acc12);
    check(win_cnt3 - base == 9, "window_count_post_reset", win_cnt3 - base, 9);

    // Input bubbles every other cycle with random consumer readiness.
    base = win_cnt3;
    fill3(1'b0, 0); push_frame3();
    rmode = 1;
    send_frame3(25, 1'b1);
    drain3();
    check(win_cnt3 - base == 9, "window_count_toggle", win_cnt3 - base, 9);

    // Random images, random bubbles and readiness, frames back to back.
    base = win_cnt3;
    rmode = 1;
    for (int f = 0; f < 3; f++) begin
      fill3(1'b1, 0); push_frame3();
      send_frame3(25, 1'($urandom_range(0, 1)));
    end
    drain3();
    check(win_cnt3 - base == 27, "window_count_random", win_cnt3 - base, 27);

    // K=5 on a 6x6 ramp.
    for (int i = 0; i < 36; i++) img5[i] = pixel_t'(i);
    push_frame5();
    send_frame5();
    repeat (4) @(posedge clk);
    #1;
    check(q5.size() == 0, "drain5_queue_empty", q5.size(), 0);
    check(win_cnt5 == 4, "window_count_k5", win_cnt5, 4);
    check(wcyc5[0] == acc28, "first_window_latency_k5", wcyc5[0], acc28);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
